// File: rtl/wb_master_pipelined_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_master_pipelined_if
//  Description : Command, write/read data streams and Wishbone pipelined bus
//                bundle for wb_master_pipelined. The master modport is the
//                bus master's view; the slave modport is the environment's.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_master_pipelined_if #(
    parameter int ADR_W = 16,
    parameter int DAT_W = 16,
    parameter int LEN_W = 8
);
    // command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_we;
    logic [ADR_W-1:0] cmd_adr;
    logic [LEN_W-1:0] cmd_len;
    // write data stream
    logic [DAT_W-1:0] wdata;
    logic             wdata_valid;
    logic             wdata_ready;
    // read data stream and completion
    logic [DAT_W-1:0] rdata;
    logic             rdata_valid;
    logic             done;
    // Wishbone pipelined bus
    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_o;
    logic [DAT_W-1:0] dat_i;
    logic             ack;
    logic             stall;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_len, wdata, wdata_valid,
        input  dat_i, ack, stall,
        output cmd_ready, wdata_ready, rdata, rdata_valid, done,
        output cyc, stb, we, adr, dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_len, wdata, wdata_valid,
        output dat_i, ack, stall,
        input  cmd_ready, wdata_ready, rdata, rdata_valid, done,
        input  cyc, stb, we, adr, dat_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_master_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : wb_master_pipelined
//  Description : Wishbone classic-pipelined bus master. Converts one command
//                (direction, start address, length) into a burst of pipelined
//                strobes, honours STALL, bounds outstanding acknowledges and
//                streams write data in / read data out.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_master_pipelined #(
    parameter int ADR_W   = 16,
    parameter int DAT_W   = 16,
    parameter int LEN_W   = 8,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_master_pipelined_if.master bus
);
    localparam int c_pend_w = $clog2(MAX_OUT + 1);
    localparam int c_cnt_w  = LEN_W + 1;
    localparam logic [c_pend_w-1:0] c_max_out = c_pend_w'(MAX_OUT);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_bus   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic [ADR_W-1:0]    r_adr;
    logic [ADR_W-1:0]    r_next_adr;
    logic [DAT_W-1:0]    r_dat_o;
    logic [DAT_W-1:0]    r_rdata;
    logic                r_rdata_valid;
    logic                r_done;
    logic [c_cnt_w-1:0]  r_to_load;   // strobes still to be loaded
    logic [c_pend_w-1:0] r_pending;   // accepted but not yet acknowledged

    logic                w_idle;
    logic                w_take;
    logic                w_accept;
    logic                w_ack_ok;
    logic [c_pend_w-1:0] w_pend_nxt;
    logic [c_cnt_w-1:0]  w_cmd_total;
    logic [c_cnt_w-1:0]  w_left;
    logic                w_cur_we;
    logic [ADR_W-1:0]    w_base_adr;
    logic                w_issuing;
    logic                w_load;
    logic                w_last_acc;
    logic                w_finish;

    assign w_idle   = (r_state == c_st_idle);
    assign w_take   = w_idle & bus.cmd_valid;
    assign w_accept = r_stb & ~bus.stall;
    // stray acks (bus idle or nothing outstanding) are dropped
    assign w_ack_ok = bus.ack & r_cyc & (r_pending != '0);
    assign w_pend_nxt = r_pending + c_pend_w'(w_accept) - c_pend_w'(w_ack_ok);

    // length 0 encodes a full 2**LEN_W burst
    assign w_cmd_total = (bus.cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                             : {1'b0, bus.cmd_len};

    // the first strobe is loaded straight from the command in the accept cycle
    assign w_left     = w_idle ? w_cmd_total : r_to_load;
    assign w_cur_we   = w_idle ? bus.cmd_we  : r_we;
    assign w_base_adr = w_idle ? bus.cmd_adr : r_next_adr;
    assign w_issuing  = w_take | (r_state == c_st_bus);

    assign w_load = w_issuing & (w_left != '0) & (w_pend_nxt < c_max_out) &
                    (~r_stb | w_accept) & (~w_cur_we | bus.wdata_valid);

    assign w_last_acc = (r_state == c_st_bus) & w_accept & (r_to_load == '0);
    assign w_finish   = (r_state == c_st_drain) & w_ack_ok & (w_pend_nxt == '0);

    // next-state decode: issue strobes, then wait out the acks
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_take)     w_state_nxt = c_st_bus;
            c_st_bus:   if (w_last_acc) w_state_nxt = c_st_drain;
            c_st_drain: if (w_finish)   w_state_nxt = c_st_idle;
            default:                    w_state_nxt = c_st_idle;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // bus outputs, burst counters and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc         <= 1'b0;
            r_stb         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_next_adr    <= '0;
            r_dat_o       <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_to_load     <= '0;
            r_pending     <= '0;
        end else begin
            r_pending     <= w_pend_nxt;
            r_done        <= w_finish;
            r_rdata_valid <= w_ack_ok & ~r_we;
            if (w_ack_ok & ~r_we) r_rdata <= bus.dat_i;
            if (w_take) begin
                r_we  <= bus.cmd_we;
                r_cyc <= 1'b1;
            end
            if (w_issuing) begin
                r_to_load  <= w_left - c_cnt_w'(w_load);
                r_next_adr <= w_base_adr + ADR_W'(w_load);
            end
            // a stalled strobe keeps adr/dat_o because no load can happen
            if (w_load) begin
                r_stb <= 1'b1;
                r_adr <= w_base_adr;
                if (w_cur_we) r_dat_o <= bus.wdata;
            end else if (w_accept) begin
                r_stb <= 1'b0;
            end
            if (w_finish) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready   = w_idle;
    assign bus.wdata_ready = w_load & w_cur_we;
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.done        = r_done;
    assign bus.cyc         = r_cyc;
    assign bus.stb         = r_stb;
    assign bus.we          = r_we;
    assign bus.adr         = r_adr;
    assign bus.dat_o       = r_dat_o;
endmodule
`default_nettype wire

// File: tb/tb_wb_master_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_master_pipelined
//  Description : Scoreboard bench for wb_master_pipelined with a latency-
//                programmable pipelined slave model and a decoupled monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_master_pipelined;
    localparam int c_max_out = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_master_pipelined_if #(.ADR_W(16), .DAT_W(16), .LEN_W(8)) bus_if ();

    wb_master_pipelined #(
        .ADR_W(16), .DAT_W(16), .LEN_W(8), .MAX_OUT(c_max_out)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] adr;
        logic        we;
        logic [15:0] dat;
    } stb_t;

    stb_t        exp_stb[$];
    logic [15:0] exp_rd[$];
    int          exp_done = 0;

    task automatic exp_s(input logic [15:0] a, input logic w, input logic [15:0] d);
        stb_t e;
        e.adr = a; e.we = w; e.dat = d;
        exp_stb.push_back(e);
    endtask

    // slave environment controls
    int lat        = 1;
    bit stall_mode = 1'b0;
    bit starve_en  = 1'b0;
    int acks_seen  = 0;
    logic [15:0] wq[$];

    typedef struct {
        int          due;
        logic [15:0] adr;
    } ack_t;

    function automatic logic [15:0] rd_data(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : a + 16'h1000;
    endfunction

    // slave model + write data source: decide inputs at negedge, then record
    initial begin : env
        int   cyc_n;
        int   starve_left;
        ack_t ackq[$];
        ack_t na;
        cyc_n = 0;
        starve_left = 0;
        bus_if.ack = 1'b0;
        bus_if.stall = 1'b0;
        bus_if.dat_i = 16'h0;
        bus_if.wdata = 16'h0;
        bus_if.wdata_valid = 1'b0;
        forever begin
            @(negedge clk);
            cyc_n++;
            bus_if.ack = 1'b0;
            if (rst === 1'b1) begin
                ackq.delete();
            end else if (ackq.size() > 0 && ackq[0].due <= cyc_n) begin
                bus_if.ack   = 1'b1;
                bus_if.dat_i = rd_data(ackq[0].adr);
                void'(ackq.pop_front());
                acks_seen++;
            end
            bus_if.stall       = stall_mode && (cyc_n % 3 == 2);
            bus_if.wdata_valid = (wq.size() > 0) && (starve_left == 0);
            bus_if.wdata       = (wq.size() > 0) ? wq[0] : 16'h0;
            if (starve_left > 0) starve_left--;
            #1;
            if (rst !== 1'b1 && bus_if.cyc === 1'b1 && bus_if.stb === 1'b1 && bus_if.stall == 1'b0) begin
                na.due = cyc_n + lat;
                na.adr = bus_if.adr;
                ackq.push_back(na);
            end
            if (bus_if.wdata_ready === 1'b1 && bus_if.wdata_valid) begin
                void'(wq.pop_front());
                if (starve_en && wq.size() == 2) starve_left = 3;
            end
        end
    end

    // monitor: pops scoreboard entries whenever the DUT presents an event
    initial begin : mon
        int   pend;
        bit   held;
        stb_t hold_v;
        stb_t e;
        logic [15:0] r;
        pend = 0;
        held = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (held) begin
                chk("stall_hold_stb", bus_if.stb, 1);
                chk("stall_hold_adr", bus_if.adr, hold_v.adr);
                chk("stall_hold_we",  bus_if.we,  hold_v.we);
                chk("stall_hold_dat", bus_if.dat_o, hold_v.dat);
            end
            held = (bus_if.cyc === 1'b1) && (bus_if.stb === 1'b1) && (bus_if.stall == 1'b1);
            hold_v.adr = bus_if.adr;
            hold_v.we  = bus_if.we;
            hold_v.dat = bus_if.dat_o;
            if (bus_if.cyc === 1'b1 && bus_if.stb === 1'b1 && bus_if.stall == 1'b0) begin
                chk("strobe_expected", 32'(exp_stb.size() > 0), 1);
                if (exp_stb.size() > 0) begin
                    e = exp_stb.pop_front();
                    chk("strobe_adr", bus_if.adr, e.adr);
                    chk("strobe_we",  bus_if.we,  e.we);
                    if (e.we) chk("strobe_dat", bus_if.dat_o, e.dat);
                end
                pend++;
            end
            if (bus_if.ack == 1'b1 && bus_if.cyc === 1'b1 && pend > 0) pend--;
            if (bus_if.cyc === 1'b1) chk("pending_limit", 32'(pend <= c_max_out), 1);
            if (bus_if.rdata_valid === 1'b1) begin
                chk("rdata_expected", 32'(exp_rd.size() > 0), 1);
                if (exp_rd.size() > 0) begin
                    r = exp_rd.pop_front();
                    chk("rdata_value", bus_if.rdata, r);
                end
            end
            if (bus_if.done === 1'b1) begin
                chk("done_expected", 32'(exp_done > 0), 1);
                if (exp_done > 0) exp_done--;
            end
            if (rst === 1'b1) begin
                exp_stb.delete();
                exp_rd.delete();
                exp_done = 0;
                pend = 0;
                held = 1'b0;
            end
        end
    end

    task automatic send(input logic w, input logic [15:0] a, input logic [7:0] len);
        int n;
        n = 0;
        @(negedge clk);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_we    = w;
        bus_if.cmd_adr   = a;
        bus_if.cmd_len   = len;
        while (bus_if.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", bus_if.cmd_ready, 1);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_stb.size() > 0 || exp_rd.size() > 0 || exp_done > 0 ||
                bus_if.cmd_ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk(name, 32'(n < 300), 1);
    endtask

    // directed stimulus
    initial begin : stim
        int n, lows, gap, base;
        rst = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_we    = 1'b0;
        bus_if.cmd_adr   = 16'h0;
        bus_if.cmd_len   = 8'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk); #3;
        chk("rst_cyc", bus_if.cyc, 0);
        chk("rst_stb", bus_if.stb, 0);
        chk("rst_we", bus_if.we, 0);
        chk("rst_adr", bus_if.adr, 16'h0);
        chk("rst_dat_o", bus_if.dat_o, 16'h0);
        chk("rst_rdata_valid", bus_if.rdata_valid, 0);
        chk("rst_done", bus_if.done, 0);
        chk("rst_wdata_ready", bus_if.wdata_ready, 0);
        chk("rst_cmd_ready", bus_if.cmd_ready, 1);

        // single read with exact timing
        lat = 1;
        exp_s(16'h0010, 1'b0, 16'h0); exp_rd.push_back(16'hBEEF); exp_done++;
        send(1'b0, 16'h0010, 8'd1);
        #3;
        chk("t1_stb_c1", bus_if.stb, 1);
        @(negedge clk); #3;
        chk("t1_cyc_c2", bus_if.cyc, 1);
        chk("t1_stb_c2", bus_if.stb, 0);
        @(negedge clk); #3;
        chk("t1_cyc_c3", bus_if.cyc, 0);
        chk("t1_done_c3", bus_if.done, 1);
        wait_idle("t1_idle");

        // four-word write, back to back
        wq = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        exp_s(16'h0100, 1'b1, 16'h00A0); exp_s(16'h0101, 1'b1, 16'h00A1);
        exp_s(16'h0102, 1'b1, 16'h00A2); exp_s(16'h0103, 1'b1, 16'h00A3);
        exp_done++;
        send(1'b1, 16'h0100, 8'd4);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            #3;
            if (bus_if.stb === 1'b1) n++;
            @(negedge clk);
        end
        chk("t2_stb_run", n, 4);
        wait_idle("t2_idle");

        // six-word read with periodic stall
        stall_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_s(16'h0200 + 16'(i), 1'b0, 16'h0);
            exp_rd.push_back(16'h1200 + 16'(i));
        end
        exp_done++;
        send(1'b0, 16'h0200, 8'd6);
        wait_idle("t3_idle");
        stall_mode = 1'b0;

        // outstanding throttle with slow acks
        lat = 5;
        for (int i = 0; i < 4; i++) begin
            exp_s(16'h0300 + 16'(i), 1'b0, 16'h0);
            exp_rd.push_back(16'h1300 + 16'(i));
        end
        exp_done++;
        send(1'b0, 16'h0300, 8'd4);
        n = 0; lows = 0; gap = 0;
        while (n < 100) begin
            #3;
            if (bus_if.done === 1'b1) break;
            if (bus_if.cyc !== 1'b1) lows++;
            if (bus_if.stb !== 1'b1) gap++;
            @(negedge clk);
            n++;
        end
        chk("t4_done_cycle", n, 13);
        chk("t4_cyc_low", lows, 0);
        chk("t4_stb_low", gap, 9);
        wait_idle("t4_idle");
        lat = 1;

        // write across address wrap with data starvation
        wq = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3};
        exp_s(16'hFFFE, 1'b1, 16'h00B0); exp_s(16'hFFFF, 1'b1, 16'h00B1);
        exp_s(16'h0000, 1'b1, 16'h00B2); exp_s(16'h0001, 1'b1, 16'h00B3);
        exp_done++;
        starve_en = 1'b1;
        send(1'b1, 16'hFFFE, 8'd4);
        n = 0; lows = 0; gap = 0;
        while (n < 100) begin
            #3;
            if (bus_if.done === 1'b1) break;
            if (bus_if.cyc !== 1'b1) lows++;
            if (bus_if.cyc === 1'b1 && bus_if.stb !== 1'b1) gap++;
            @(negedge clk);
            n++;
        end
        chk("t5_done_cycle", n, 8);
        chk("t5_cyc_low", lows, 0);
        chk("t5_starve_gap", gap, 4);
        wait_idle("t5_idle");
        starve_en = 1'b0;

        // reset in the middle of an eight-word read
        for (int i = 0; i < 8; i++) begin
            exp_s(16'h0400 + 16'(i), 1'b0, 16'h0);
            exp_rd.push_back(16'h1400 + 16'(i));
        end
        base = acks_seen;
        send(1'b0, 16'h0400, 8'd8);
        n = 0;
        while (acks_seen - base < 2 && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("t6_two_acks", 32'(acks_seen - base >= 2), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #3;
        chk("t6_cyc", bus_if.cyc, 0);
        chk("t6_stb", bus_if.stb, 0);
        chk("t6_done", bus_if.done, 0);
        chk("t6_cmd_ready", bus_if.cmd_ready, 1);
        repeat (4) @(negedge clk);
        wait_idle("t6_idle");

        // normal read after the abandoned burst
        exp_s(16'h0500, 1'b0, 16'h0); exp_rd.push_back(16'h1500); exp_done++;
        send(1'b0, 16'h0500, 8'd1);
        wait_idle("t7_idle");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
